// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// IDLE -> ACCESS -> DONE per access (3 cycles); illegal addresses skip ACCESS and ack with err.
module dmem_arbiter #(
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [31:0]           addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            ack,
  output logic [1:0]            err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic [15:0]           mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  MemRead,
  output logic                  MemWrt,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [15:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                win;
  logic                win_we;
  logic [15:0]         win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                win_legal;
  logic [1:0]          grant_oh;

  // On a tie the requester not granted last wins; a lone request always wins.
  always_comb begin
    win       = (req == 2'b11) ? ~last_q : req[1];
    win_we    = win ? we[1] : we[0];
    win_addr  = win ? addr[31:16] : addr[15:0];
    win_wdata = win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    win_legal = !win_addr[0] && (win_addr < 16'(MEM_DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = win;
          last_d  = win;
          we_d    = win_we;
          err_d   = !win_legal;
          if (win_legal) begin
            state_d     = ACCESS;
            mem_addr_d  = win_addr;
            mem_wdata_d = win_wdata;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory data is registered, so it is valid during DONE for a legal read.
  always_comb begin
    rdata_d = rdata_q;
    if (state_q == DONE && !we_q && !err_q) rdata_d = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign grant_oh  = grant_q ? 2'b10 : 2'b01;
  assign ack       = (state_q == DONE) ? grant_oh : 2'b00;
  assign err       = (state_q == DONE && err_q) ? grant_oh : 2'b00;
  assign rdata     = rdata_d;
  assign busy      = (state_q != IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign MemRead   = (state_q == ACCESS) && !we_q;
  assign MemWrt    = (state_q == ACCESS) && we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered 16-entry memory model.
// Inputs change and outputs are checked on the falling edge.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [15:0] rdata;
  logic        busy;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        MemRead;
  logic        MemWrt;
  logic [15:0] mem_rdata;

  logic        mem_init;
  logic [15:0] mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.DATA_W(16), .MEM_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .MemRead(MemRead), .MemWrt(MemWrt), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
      mem[4] <= 16'h1234;
      mem[6] <= 16'hDEAD;
      mem[8] <= 16'hBEEF;
      mem_rdata <= 16'h0000;
    end else begin
      if (MemWrt) mem[mem_addr[3:0]] <= mem_wdata;
      if (MemRead) mem_rdata <= mem[mem_addr[3:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; mem_init = 1'b1;
    req = 2'b00; we = 2'b00; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_strobes", 32'({MemRead, MemWrt}), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    rst = 1'b1; mem_init = 1'b0;

    // Single read of address 4
    req = 2'b01; we = 2'b00; addr = 32'h0000_0004;
    @(negedge clk);
    chk("rd_access_MemRead", 32'(MemRead), 32'h1);
    chk("rd_access_MemWrt", 32'(MemWrt), 32'h0);
    chk("rd_access_addr", 32'(mem_addr), 32'h4);
    chk("rd_access_busy", 32'(busy), 32'h1);
    chk("rd_access_ack", 32'(ack), 32'h0);
    @(negedge clk);
    chk("rd_done_ack", 32'(ack), 32'h1);
    chk("rd_done_err", 32'(err), 32'h0);
    chk("rd_done_rdata", 32'(rdata), 32'h1234);
    chk("rd_done_MemRead", 32'(MemRead), 32'h0);
    req = 2'b00;
    @(negedge clk);
    chk("rd_idle_ack", 32'(ack), 32'h0);
    chk("rd_idle_busy", 32'(busy), 32'h0);
    chk("rd_idle_rdata_hold", 32'(rdata), 32'h1234);

    // Write 0x00A5 to address 2, then read it back with req held across ack
    req = 2'b01; we = 2'b01; addr = 32'h0000_0002; wdata = 32'h0000_00A5;
    @(negedge clk);
    chk("wr_access_MemWrt", 32'(MemWrt), 32'h1);
    chk("wr_access_MemRead", 32'(MemRead), 32'h0);
    chk("wr_access_addr", 32'(mem_addr), 32'h2);
    chk("wr_access_wdata", 32'(mem_wdata), 32'h00A5);
    @(negedge clk);
    chk("wr_done_ack", 32'(ack), 32'h1);
    chk("wr_done_rdata_hold", 32'(rdata), 32'h1234);
    chk("wr_done_addr_hold", 32'(mem_addr), 32'h2);
    chk("wr_done_MemWrt", 32'(MemWrt), 32'h0);
    we = 2'b00;
    @(negedge clk);
    chk("wr_idle_busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("rb_access_MemRead", 32'(MemRead), 32'h1);
    chk("rb_access_addr", 32'(mem_addr), 32'h2);
    @(negedge clk);
    chk("rb_done_ack", 32'(ack), 32'h1);
    chk("rb_done_rdata", 32'(rdata), 32'h00A5);

    // Reset pulse, then a held tie must alternate grants starting with 0
    req = 2'b00; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req = 2'b11; we = 2'b00; addr = 32'h0008_0006;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("tie%0d_access_addr", k), 32'(mem_addr), (k % 2 == 0) ? 32'h6 : 32'h8);
      chk($sformatf("tie%0d_access_MemRead", k), 32'(MemRead), 32'h1);
      @(negedge clk);
      chk($sformatf("tie%0d_ack", k), 32'(ack), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("tie%0d_rdata", k), 32'(rdata), (k % 2 == 0) ? 32'hDEAD : 32'hBEEF);
      if (k == 3) req = 2'b00;
      @(negedge clk);
      chk($sformatf("tie%0d_idle_ack", k), 32'(ack), 32'h0);
    end

    // Illegal addresses from requester 1: odd address, then address == depth
    req = 2'b10; we = 2'b00; addr = 32'h0003_0000;
    @(negedge clk);
    chk("ill_odd_ack", 32'(ack), 32'h2);
    chk("ill_odd_err", 32'(err), 32'h2);
    chk("ill_odd_strobes", 32'({MemRead, MemWrt}), 32'h0);
    chk("ill_odd_busy", 32'(busy), 32'h1);
    addr = 32'h0010_0000;
    @(negedge clk);
    chk("ill_idle_ack", 32'(ack), 32'h0);
    chk("ill_idle_err", 32'(err), 32'h0);
    chk("ill_idle_strobes", 32'({MemRead, MemWrt}), 32'h0);
    @(negedge clk);
    chk("ill_big_ack", 32'(ack), 32'h2);
    chk("ill_big_err", 32'(err), 32'h2);
    chk("ill_big_strobes", 32'({MemRead, MemWrt}), 32'h0);
    chk("ill_big_addr_hold", 32'(mem_addr), 32'h8);
    chk("ill_big_rdata_hold", 32'(rdata), 32'hBEEF);
    req = 2'b00;
    @(negedge clk);

    // Reset during the ACCESS of a write: discarded, memory untouched
    req = 2'b01; we = 2'b01; addr = 32'h0000_0004; wdata = 32'h0000_5555;
    @(negedge clk);
    chk("rstm_access_MemWrt", 32'(MemWrt), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("rstm_now_strobes", 32'({MemRead, MemWrt}), 32'h0);
    chk("rstm_now_busy", 32'(busy), 32'h0);
    chk("rstm_now_mem_addr", 32'(mem_addr), 32'h0);
    chk("rstm_now_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rstm_now_rdata", 32'(rdata), 32'h0);
    chk("rstm_now_ack_err", 32'({ack, err}), 32'h0);
    @(negedge clk);
    chk("rstm_no_ack", 32'(ack), 32'h0);
    rst = 1'b1;
    req = 2'b11; we = 2'b00; addr = 32'h0006_0004;
    @(negedge clk);
    chk("rstm_first_addr", 32'(mem_addr), 32'h4);
    @(negedge clk);
    chk("rstm_first_ack", 32'(ack), 32'h1);
    chk("rstm_first_rdata", 32'(rdata), 32'h1234);
    req = 2'b00;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
